// File: rtl/motorpasso_ram_arbiter_pkg.sv
// Shared types and defaults for the two-requester single-port RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package motorpasso_ram_arbiter_pkg;

  // Arbiter FSM: GRANTn means requester n had a command accepted in the
  // previous cycle; IDLE means nothing was accepted.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF   = 13;
  localparam int DATA_W_DEF   = 32;
  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/motorpasso_ram_arbiter_if.sv
// Avalon-MM style requester port: one command bus plus waitrequest/readdatavalid.
// Latency: n/a (bundle only); readdata follows an accepted read by READ_LATENCY.
// Backpressure: waitrequest high holds the master's command in place.
// Modports: master (requester side drives the command), slave (arbiter side answers).
interface motorpasso_ram_arbiter_if
  import motorpasso_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = DATA_W / 8
) ();

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/motorpasso_rr_pick2.sv
// Two-way grant picker: at most one grant, only to a requesting input.
// Latency: combinational.
// Backpressure: n/a; a losing requester simply sees no grant this cycle.
// Ports: req[1:0] in, last_served in (round-robin build only), gnt[1:0] out.
// Build option MOTORPASSO_ARB_FIXED_PRIO_EN: requester 0 always wins, no last_served input.
module motorpasso_rr_pick2 (
  input  logic [1:0] req,
`ifndef MOTORPASSO_ARB_FIXED_PRIO_EN
  input  logic       last_served,
`endif
  output logic [1:0] gnt
);

`ifdef MOTORPASSO_ARB_FIXED_PRIO_EN
  assign gnt[0] = req[0];
  assign gnt[1] = req[1] & ~req[0];
`else
  // On contention the requester that was not served last wins.
  assign gnt[0] = req[0] & (~req[1] | last_served);
  assign gnt[1] = req[1] & (~req[0] | ~last_served);
`endif

endmodule

// File: rtl/motorpasso_ram_arbiter.sv
// Shares one single-port RAM between two Avalon-MM requesters, one command per cycle.
// Latency: command reaches mem_* combinationally in the accept cycle; read data returns 1 cycle later.
// Backpressure: the losing (or not-yet-running) requester sees waitrequest=1 and holds its command.
// Ports: clk, reset (async, active-high); m0/m1 requester slave modports;
//        mem_* single-port RAM side (mem_readdata valid one cycle after the address cycle); busy.
// Build option MOTORPASSO_ARB_FIXED_PRIO_EN: fixed priority to requester 0 instead of round-robin.
module motorpasso_ram_arbiter
  import motorpasso_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  motorpasso_ram_arbiter_if.slave m0,
  motorpasso_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]      mem_address,
  output logic                   mem_chipselect,
  output logic                   mem_write,
  output logic [DATA_W-1:0]      mem_writedata,
  output logic [BE_W-1:0]        mem_byteenable,
  output logic                   mem_clken,
  input  logic [DATA_W-1:0]      mem_readdata,
  output logic                   busy
);

  arb_state_t state_q, state_d;
  logic       run_q;       // low from reset until the first clk edge after release
  logic       rd_vld_q;    // a read was accepted last cycle
  logic       rd_owner_q;  // requester that owns that read
  logic [1:0] req, gnt;
  logic       acc, acc_write;

  // Requests are ignored until run_q rises, so no output leaves its reset
  // value before the first clock edge after reset is released.
  assign req = {m1.read | m1.write, m0.read | m0.write} & {2{run_q}};

`ifdef MOTORPASSO_ARB_FIXED_PRIO_EN
  motorpasso_rr_pick2 u_pick (
    .req (req),
    .gnt (gnt)
  );
`else
  logic last_served_q, last_served;

  // The FSM state already records who was accepted last cycle; the stored
  // copy only carries the answer across IDLE stretches.
  always_comb begin
    last_served = last_served_q;
    if (state_q == GRANT0) last_served = 1'b0;
    else if (state_q == GRANT1) last_served = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_served_q <= 1'b1;
    else       last_served_q <= last_served;
  end

  motorpasso_rr_pick2 u_pick (
    .req         (req),
    .last_served (last_served),
    .gnt         (gnt)
  );
`endif

  // A grant is only ever given to a requesting port, so grant == acceptance.
  assign acc       = |gnt;
  assign acc_write = gnt[1] ? m1.write : m0.write;  // read+write together counts as a write

  always_comb begin
    state_d = IDLE;
    if (gnt[0])      state_d = GRANT0;
    else if (gnt[1]) state_d = GRANT1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      state_q    <= IDLE;
      rd_vld_q   <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      state_q  <= state_d;
      rd_vld_q <= acc & ~acc_write;
      if (acc) rd_owner_q <= gnt[1];
    end
  end

  assign mem_address    = gnt[1] ? m1.address    : m0.address;
  assign mem_writedata  = gnt[1] ? m1.writedata  : m0.writedata;
  assign mem_byteenable = gnt[1] ? m1.byteenable : m0.byteenable;
  assign mem_chipselect = acc;
  assign mem_write      = acc & acc_write;
  assign mem_clken      = run_q;

  assign m0.waitrequest   = ~gnt[0];
  assign m1.waitrequest   = ~gnt[1];
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_vld_q & ~rd_owner_q;
  assign m1.readdatavalid = rd_vld_q &  rd_owner_q;

  assign busy = (|req) | rd_vld_q;

endmodule

// File: tb/tb_motorpasso_ram_arbiter.sv
// Bench for motorpasso_ram_arbiter: RAM model on the mem_* side, reference
// memory plus arbitration rule model, read expectations queued per requester.
// Latency: n/a. Backpressure: requesters hold commands while waitrequest=1.
module tb_motorpasso_ram_arbiter;
  import motorpasso_ram_arbiter_pkg::*;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  motorpasso_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0_if ();
  motorpasso_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1_if ();

  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken, busy;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [BW-1:0] mem_byteenable;

  motorpasso_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Requester command registers, driven by the stimulus process.
  logic          rq_read [2];
  logic          rq_write[2];
  logic [AW-1:0] rq_addr [2];
  logic [DW-1:0] rq_wdata[2];
  logic [BW-1:0] rq_be   [2];

  assign m0_if.read = rq_read[0];  assign m0_if.write = rq_write[0];
  assign m0_if.address = rq_addr[0]; assign m0_if.writedata = rq_wdata[0];
  assign m0_if.byteenable = rq_be[0];
  assign m1_if.read = rq_read[1];  assign m1_if.write = rq_write[1];
  assign m1_if.address = rq_addr[1]; assign m1_if.writedata = rq_wdata[1];
  assign m1_if.byteenable = rq_be[1];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    merge = old;
    for (int b = 0; b < BW; b++) if (be[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  // Single-port RAM: registered read data, one cycle after the address cycle.
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      mem_readdata <= ram[mem_address];
    end
  end

  // Reference model state.
  typedef struct { int cyc; logic [DW-1:0] data; } exp_t;
  logic [DW-1:0] ref_mem [2**AW];
  exp_t exp_q [2][$];
  int   grant_log[$];
  int   model_last = 1;
  bit   rd_out = 1'b0;
  bit   acc_flag[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Observer: decides the expected winner from the arbitration rules, checks
  // the memory-side command and queues expected read data.
  bit o_req[2], o_acc[2];
  int o_w;
  exp_t o_e;
  always @(negedge clk) begin
    if (!reset) begin
      o_req[0] = rq_read[0] | rq_write[0];
      o_req[1] = rq_read[1] | rq_write[1];
      o_acc[0] = o_req[0] && !m0_if.waitrequest;
      o_acc[1] = o_req[1] && !m1_if.waitrequest;
      chk("busy", busy, o_req[0] | o_req[1] | rd_out);
      if (o_req[0] || o_req[1]) begin
`ifdef MOTORPASSO_ARB_FIXED_PRIO_EN
        o_w = o_req[0] ? 0 : 1;
`else
        if (o_req[0] && o_req[1]) o_w = (model_last == 1) ? 0 : 1;
        else                      o_w = o_req[0] ? 0 : 1;
`endif
        chk("grant", {o_acc[1], o_acc[0]}, (o_w == 0) ? 2'b01 : 2'b10);
        chk("mem_chipselect", mem_chipselect, 1);
        chk("mem_address", mem_address, rq_addr[o_w]);
        chk("mem_write", mem_write, rq_write[o_w]);
        if (rq_write[o_w]) begin
          chk("mem_writedata", mem_writedata, rq_wdata[o_w]);
          chk("mem_byteenable", mem_byteenable, rq_be[o_w]);
          ref_mem[rq_addr[o_w]] = merge(ref_mem[rq_addr[o_w]], rq_wdata[o_w], rq_be[o_w]);
          rd_out = 1'b0;
        end else begin
          o_e.cyc  = cyc + READ_LATENCY;
          o_e.data = ref_mem[rq_addr[o_w]];
          exp_q[o_w].push_back(o_e);
          rd_out = 1'b1;
        end
        model_last = o_w;
        grant_log.push_back(o_w);
      end else begin
        chk("mem_chipselect_idle", mem_chipselect, 0);
        rd_out = 1'b0;
      end
      if (o_acc[0]) acc_flag[0] = 1'b1;
      if (o_acc[1]) acc_flag[1] = 1'b1;
    end
  end

  // Monitor: pops expectations whenever a readdatavalid appears.
  exp_t m_e;
  task automatic mon_port(input int n, input logic vld, input logic [DW-1:0] dat);
    if (exp_q[n].size() > 0 && exp_q[n][0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL rdv_missing_m%0d: readdatavalid absent, expected at cycle %0d", n, exp_q[n][0].cyc);
      void'(exp_q[n].pop_front());
    end
    if (vld !== 1'b0) begin
      if (exp_q[n].size() == 0) begin
        tests++; fails++;
        $display("FAIL rdv_unexpected_m%0d: readdatavalid=%b with nothing outstanding (cycle %0d)",
                 n, vld, cyc);
      end else begin
        m_e = exp_q[n].pop_front();
        chk($sformatf("rdv_cycle_m%0d", n), cyc, m_e.cyc);
        chk($sformatf("readdata_m%0d", n), dat, m_e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_port(0, m0_if.readdatavalid, m0_if.readdata);
    mon_port(1, m1_if.readdatavalid, m1_if.readdata);
  end

  task automatic clear_rq();
    for (int n = 0; n < 2; n++) begin
      rq_read[n] = 1'b0; rq_write[n] = 1'b0; rq_addr[n] = '0; rq_wdata[n] = '0; rq_be[n] = '0;
    end
  endtask

  // Issue one command and hold it until accepted (bounded), then drop it.
  task automatic do_cmd(input int n, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    int b;
    b = 0;
    @(posedge clk); #1;
    acc_flag[n] = 1'b0;
    rq_read[n] = rd; rq_write[n] = wr; rq_addr[n] = a; rq_wdata[n] = d; rq_be[n] = be;
    @(posedge clk); #1;
    while (!acc_flag[n] && b < 50) begin
      @(posedge clk); #1;
      b++;
    end
    chk($sformatf("accepted_m%0d", n), acc_flag[n], 1);
    acc_flag[n] = 1'b0;
    rq_read[n] = 1'b0; rq_write[n] = 1'b0;
  endtask

  task automatic model_reset();
    exp_q[0].delete(); exp_q[1].delete();
    grant_log.delete();
    rd_out = 1'b0; model_last = 1;
    acc_flag[0] = 1'b0; acc_flag[1] = 1'b0;
  endtask

  // Entered with reset high: both requesters read continuously across the
  // release; grants must alternate starting with requester 0.
  task automatic both_from_reset(input string tag);
    @(posedge clk); #1;
    rq_read[0] = 1'b1; rq_addr[0] = 13'h0001; rq_write[0] = 1'b0;
    rq_read[1] = 1'b1; rq_addr[1] = 13'h0002; rq_write[1] = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_m0_wait"}, m0_if.waitrequest, 1);
    chk({tag, "_rst_m1_wait"}, m1_if.waitrequest, 1);
    chk({tag, "_rst_m0_rdv"}, m0_if.readdatavalid, 0);
    chk({tag, "_rst_m1_rdv"}, m1_if.readdatavalid, 0);
    chk({tag, "_rst_cs"}, mem_chipselect, 0);
    chk({tag, "_rst_mem_write"}, mem_write, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    chk({tag, "_rst_clken"}, mem_clken, 0);
    #1 reset = 1'b0;
    #2;
    chk({tag, "_release_m0_wait"}, m0_if.waitrequest, 1);
    chk({tag, "_release_cs"}, mem_chipselect, 0);
    repeat (5) @(posedge clk);
    #1;
    rq_read[0] = 1'b0; rq_read[1] = 1'b0;
    chk({tag, "_clken"}, mem_clken, 1);
    chk({tag, "_grant_count"}, grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk($sformatf("%s_grant%0d", tag, i), grant_log[i], i % 2);
  endtask

  int unsigned r;
  initial begin
    for (int i = 0; i < 2**AW; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    clear_rq();
    acc_flag[0] = 1'b0; acc_flag[1] = 1'b0;
    reset = 1'b1;
    both_from_reset("por");
    repeat (3) @(posedge clk);

    do_cmd(0, 0, 1, 13'h0010, 32'hDEADBEEF, 4'hF);
    do_cmd(0, 1, 0, 13'h0010, 32'h0, 4'hF);

    do_cmd(1, 0, 1, 13'h0020, 32'h11223344, 4'hF);
    do_cmd(1, 0, 1, 13'h0020, 32'h000000AA, 4'h1);
    do_cmd(1, 1, 0, 13'h0020, 32'h0, 4'hF);

    do_cmd(0, 1, 1, 13'h0100, 32'h5, 4'hF);
    do_cmd(0, 1, 0, 13'h0100, 32'h0, 4'hF);

`ifdef MOTORPASSO_ARB_FIXED_PRIO_EN
    @(posedge clk); #1;
    rq_read[0] = 1'b1; rq_addr[0] = 13'h0005;
    rq_read[1] = 1'b1; rq_addr[1] = 13'h0006;
    repeat (6) begin
      @(negedge clk);
      chk("fixed_m1_wait", m1_if.waitrequest, 1);
    end
    @(posedge clk); #1;
    rq_read[0] = 1'b0;
    acc_flag[1] = 1'b0;
    @(negedge clk);
    chk("fixed_m1_served", m1_if.waitrequest, 0);
    @(posedge clk); #1;
    rq_read[1] = 1'b0;
`endif

    // Reset lands in the cycle after an m0 read is accepted: its data is dropped.
    do_cmd(0, 1, 0, 13'h0010, 32'h0, 4'hF);
    reset = 1'b1;
    model_reset();
    both_from_reset("pulse");

    // Randomized traffic over a small address window to force collisions.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (acc_flag[n] || !(rq_read[n] || rq_write[n])) begin
          acc_flag[n] = 1'b0;
          r = $urandom_range(0, 9);
          rq_read[n]  = (r >= 3 && r <= 6) || r == 9;
          rq_write[n] = (r >= 7);
          rq_addr[n]  = AW'($urandom_range(0, 15));
          rq_wdata[n] = $urandom;
          rq_be[n]    = BW'($urandom_range(0, 15));
        end
      end
    end

    @(posedge clk); #1;
    clear_rq();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_m0", exp_q[0].size(), 0);
    chk("drain_m1", exp_q[1].size(), 0);
    chk("idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
